// File: rtl/acc_mmu_arbiter.sv
// acc_mmu_arbiter
//   Round-robin arbiter that lets up to NrChannels accelerator requesters share
//   one MMU translation port. Only one translation is in flight at a time.
//   The winner's request is latched on grant and presented to the MMU from the
//   following cycle. The MMU response is broadcast and qualified per channel by
//   ch_valid_o. Dropping en_i while a translation is outstanding aborts it.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   en_i                           accelerator MMU enable
//   ch_req_i/vaddr/is_store/
//   misaligned_ex_i                per-channel translation requests
//   ch_gnt_o/valid_o/abort_o       per-channel grant, completion, abort pulses
//   ch_paddr_o/exception_o/
//   dtlb_hit_o/dtlb_ppn_o          broadcast response fields (0 unless valid)
//   mmu_*_o / mmu_*_i              shared MMU request / response port
//   stat_grants_o, stat_stall_o    saturating statistics counters
//
// Build option
//   ACC_MMU_ARB_STATS_EN           when defined, the statistics counters exist;
//                                  otherwise both stat outputs are tied to 0.
//
// States
//   IDLE | no translation outstanding; may grant a requester
//   BUSY | latched request presented to the MMU, waiting for completion/abort

module acc_mmu_arbiter #(
  parameter int unsigned NrChannels = 2,
  parameter int unsigned VLEN       = 64,
  parameter int unsigned PLEN       = 56,
  parameter int unsigned PPNW       = 44,
  parameter int unsigned ExcW       = 203
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  input  logic [NrChannels-1:0]      ch_req_i,
  input  logic [NrChannels*VLEN-1:0] ch_vaddr_i,
  input  logic [NrChannels-1:0]      ch_is_store_i,
  input  logic [NrChannels-1:0]      ch_misaligned_ex_i,
  output logic [NrChannels-1:0]      ch_gnt_o,
  output logic [NrChannels-1:0]      ch_valid_o,
  output logic [NrChannels-1:0]      ch_abort_o,
  output logic [PLEN-1:0]            ch_paddr_o,
  output logic [ExcW-1:0]            ch_exception_o,
  output logic                       ch_dtlb_hit_o,
  output logic [PPNW-1:0]            ch_dtlb_ppn_o,
  output logic                       mmu_req_o,
  output logic [VLEN-1:0]            mmu_vaddr_o,
  output logic                       mmu_is_store_o,
  output logic                       mmu_misaligned_ex_o,
  input  logic                       mmu_valid_i,
  input  logic [PLEN-1:0]            mmu_paddr_i,
  input  logic [ExcW-1:0]            mmu_exception_i,
  input  logic                       mmu_dtlb_hit_i,
  input  logic [PPNW-1:0]            mmu_dtlb_ppn_i,
  output logic [31:0]                stat_grants_o,
  output logic [31:0]                stat_stall_o
);

  localparam int unsigned PW = (NrChannels > 1) ? $clog2(NrChannels) : 1;
  localparam logic [NrChannels-1:0] ONE = 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [PW-1:0]         rr_ptr_q, owner_q, winner, next_ptr;
  logic                  found;
  logic                  armed_q;
  logic [VLEN-1:0]       vaddr_q;
  logic                  is_store_q, misaligned_q;
  logic [NrChannels-1:0] req_sh;
  int unsigned           idx;
  logic                  grant, complete, abort;

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    req_sh = '0;
    for (int unsigned i = 0; i < NrChannels; i++) begin
      idx    = (32'(rr_ptr_q) + i) % NrChannels;
      req_sh = ch_req_i >> idx;
      if (!found && req_sh[0]) begin
        winner = PW'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    if (owner_q == PW'(NrChannels - 1)) next_ptr = '0;
    else                                next_ptr = owner_q + 1'b1;
  end

  // armed_q keeps grants off during the first cycle after reset release.
  assign grant    = (state_q == IDLE) && en_i && found && armed_q;
  assign complete = (state_q == BUSY) && mmu_valid_i;
  assign abort    = (state_q == BUSY) && !en_i && !mmu_valid_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = BUSY;
      BUSY:    if (complete || abort) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      armed_q      <= 1'b0;
      vaddr_q      <= '0;
      is_store_q   <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      if (grant) begin
        owner_q      <= winner;
        vaddr_q      <= ch_vaddr_i[32'(winner)*VLEN +: VLEN];
        is_store_q   <= ch_is_store_i[winner];
        misaligned_q <= ch_misaligned_ex_i[winner];
      end
      if (complete || abort) rr_ptr_q <= next_ptr;
    end
  end

  assign ch_gnt_o   = grant    ? (ONE << winner)  : '0;
  assign ch_valid_o = complete ? (ONE << owner_q) : '0;
  assign ch_abort_o = abort    ? (ONE << owner_q) : '0;

  assign ch_paddr_o     = complete ? mmu_paddr_i     : '0;
  assign ch_exception_o = complete ? mmu_exception_i : '0;
  assign ch_dtlb_hit_o  = complete && mmu_dtlb_hit_i;
  assign ch_dtlb_ppn_o  = complete ? mmu_dtlb_ppn_i  : '0;

  // A completing cycle keeps the request up even if en_i has just dropped.
  assign mmu_req_o           = (state_q == BUSY) && (en_i || mmu_valid_i);
  assign mmu_vaddr_o         = vaddr_q;
  assign mmu_is_store_o      = is_store_q;
  assign mmu_misaligned_ex_o = misaligned_q;

`ifdef ACC_MMU_ARB_STATS_EN
  logic [31:0] grants_q, stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grants_q <= '0;
      stall_q  <= '0;
    end else begin
      if (grant && (grants_q != 32'hFFFF_FFFF)) grants_q <= grants_q + 32'd1;
      if (armed_q && (|ch_req_i) && !grant && (stall_q != 32'hFFFF_FFFF))
        stall_q <= stall_q + 32'd1;
    end
  end

  assign stat_grants_o = grants_q;
  assign stat_stall_o  = stall_q;
`else
  assign stat_grants_o = 32'd0;
  assign stat_stall_o  = 32'd0;
`endif

endmodule

// File: tb/tb_acc_mmu_arbiter.sv
// Directed testbench for acc_mmu_arbiter with default parameters
// (2 channels). Inputs change 1 time unit after the rising edge, outputs
// are sampled on the falling edge.

module tb_acc_mmu_arbiter;

  localparam int NC   = 2;
  localparam int VLEN = 64;
  localparam int PLEN = 56;
  localparam int PPNW = 44;
  localparam int ExcW = 203;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               en_i;
  logic [NC-1:0]      ch_req_i;
  logic [NC*VLEN-1:0] ch_vaddr_i;
  logic [NC-1:0]      ch_is_store_i;
  logic [NC-1:0]      ch_misaligned_ex_i;
  logic [NC-1:0]      ch_gnt_o, ch_valid_o, ch_abort_o;
  logic [PLEN-1:0]    ch_paddr_o;
  logic [ExcW-1:0]    ch_exception_o;
  logic               ch_dtlb_hit_o;
  logic [PPNW-1:0]    ch_dtlb_ppn_o;
  logic               mmu_req_o;
  logic [VLEN-1:0]    mmu_vaddr_o;
  logic               mmu_is_store_o, mmu_misaligned_ex_o;
  logic               mmu_valid_i;
  logic [PLEN-1:0]    mmu_paddr_i;
  logic [ExcW-1:0]    mmu_exception_i;
  logic               mmu_dtlb_hit_i;
  logic [PPNW-1:0]    mmu_dtlb_ppn_i;
  logic [31:0]        stat_grants_o, stat_stall_o;

  int vectors = 0;
  int errors  = 0;

  always #5 clk_i = ~clk_i;

  acc_mmu_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
    .ch_req_i(ch_req_i), .ch_vaddr_i(ch_vaddr_i),
    .ch_is_store_i(ch_is_store_i), .ch_misaligned_ex_i(ch_misaligned_ex_i),
    .ch_gnt_o(ch_gnt_o), .ch_valid_o(ch_valid_o), .ch_abort_o(ch_abort_o),
    .ch_paddr_o(ch_paddr_o), .ch_exception_o(ch_exception_o),
    .ch_dtlb_hit_o(ch_dtlb_hit_o), .ch_dtlb_ppn_o(ch_dtlb_ppn_o),
    .mmu_req_o(mmu_req_o), .mmu_vaddr_o(mmu_vaddr_o),
    .mmu_is_store_o(mmu_is_store_o), .mmu_misaligned_ex_o(mmu_misaligned_ex_o),
    .mmu_valid_i(mmu_valid_i), .mmu_paddr_i(mmu_paddr_i),
    .mmu_exception_i(mmu_exception_i), .mmu_dtlb_hit_i(mmu_dtlb_hit_i),
    .mmu_dtlb_ppn_i(mmu_dtlb_ppn_i),
    .stat_grants_o(stat_grants_o), .stat_stall_o(stat_stall_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    en_i               = 1'b0;
    ch_req_i           = '0;
    ch_vaddr_i         = '0;
    ch_is_store_i      = '0;
    ch_misaligned_ex_i = '0;
    mmu_valid_i        = 1'b0;
    mmu_paddr_i        = '0;
    mmu_exception_i    = '0;
    mmu_dtlb_hit_i     = 1'b0;
    mmu_dtlb_ppn_i     = '0;
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    clear_inputs();
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    clear_inputs();
    en_i        = 1'b1;
    ch_req_i    = 2'b11;
    mmu_valid_i = 1'b1;
    mmu_paddr_i = 56'h12_3456;
    @(negedge clk_i);
    vectors++;
    if (ch_gnt_o !== 2'b00 || mmu_req_o !== 1'b0 || ch_valid_o !== 2'b00 || ch_paddr_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b req=%b valid=%b paddr=%h, want all 0", ch_gnt_o, mmu_req_o, ch_valid_o, ch_paddr_o);
    end
    vectors++;
    if (stat_grants_o !== 32'd0 || stat_stall_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_stats: grants=%0d stall=%0d, want 0 0", stat_grants_o, stat_stall_o);
    end
    tick();
    rst_ni = 1'b1;
    @(negedge clk_i);
    vectors++;
    if (ch_gnt_o !== 2'b00 || ch_valid_o !== 2'b00 || mmu_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_cycle: gnt=%b valid=%b req=%b, want 0", ch_gnt_o, ch_valid_o, mmu_req_o);
    end
    tick();
    mmu_valid_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if (ch_gnt_o !== 2'b01) begin
      errors++;
      $display("FAIL reset_first_grant: got %b want 01", ch_gnt_o);
    end
    tick();
    @(negedge clk_i);
    vectors++;
    if (mmu_req_o !== 1'b1) begin
      errors++;
      $display("FAIL busy_req: got %b want 1", mmu_req_o);
    end
    // Reset in the middle of BUSY while the MMU answers.
    rst_ni      = 1'b0;
    mmu_valid_i = 1'b1;
    #1;
    vectors++;
    if (ch_valid_o !== 2'b00 || ch_abort_o !== 2'b00 || mmu_req_o !== 1'b0 || ch_gnt_o !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_busy: valid=%b abort=%b req=%b gnt=%b, want 0", ch_valid_o, ch_abort_o, mmu_req_o, ch_gnt_o);
    end
    tick();
    rst_ni      = 1'b1;
    mmu_valid_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if (ch_gnt_o !== 2'b00 || ch_valid_o !== 2'b00 || ch_abort_o !== 2'b00) begin
      errors++;
      $display("FAIL reset_release_quiet: gnt=%b valid=%b abort=%b, want 0", ch_gnt_o, ch_valid_o, ch_abort_o);
    end
    tick();
    @(negedge clk_i);
    vectors++;
    if (ch_gnt_o !== 2'b01) begin
      errors++;
      $display("FAIL reset_release_ch0: got %b want 01", ch_gnt_o);
    end
    tick();
    mmu_valid_i = 1'b1;
    @(negedge clk_i);
    vectors++;
    if (ch_valid_o !== 2'b01) begin
      errors++;
      $display("FAIL reset_release_done: got %b want 01", ch_valid_o);
    end
    tick();
    mmu_valid_i = 1'b0;
    ch_req_i    = 2'b00;
    tick();
  endtask

  task automatic test_single();
    en_i                 = 1'b1;
    ch_req_i             = 2'b10;
    ch_vaddr_i[VLEN +: VLEN] = 64'h8000_1000;
    ch_vaddr_i[0 +: VLEN]    = 64'hDEAD_0000;
    ch_is_store_i        = 2'b10;
    ch_misaligned_ex_i   = 2'b01;
    @(negedge clk_i);
    vectors++;
    if (ch_gnt_o !== 2'b10) begin
      errors++;
      $display("FAIL single_gnt: got %b want 10", ch_gnt_o);
    end
    tick();
    ch_req_i   = 2'b00;
    ch_vaddr_i = '0;
    @(negedge clk_i);
    vectors++;
    if (mmu_req_o !== 1'b1 || mmu_vaddr_o !== 64'h8000_1000 || mmu_is_store_o !== 1'b1 || mmu_misaligned_ex_o !== 1'b0) begin
      errors++;
      $display("FAIL single_mmu: req=%b vaddr=%h st=%b mis=%b, want 1 80001000 1 0", mmu_req_o, mmu_vaddr_o, mmu_is_store_o, mmu_misaligned_ex_o);
    end
    tick();
    mmu_valid_i    = 1'b1;
    mmu_paddr_i    = 56'h8000_1000;
    mmu_dtlb_hit_i = 1'b1;
    mmu_dtlb_ppn_i = 44'h8_0001;
    @(negedge clk_i);
    vectors++;
    if (ch_valid_o !== 2'b10 || ch_paddr_o !== 56'h8000_1000 || ch_dtlb_hit_o !== 1'b1 || ch_dtlb_ppn_o !== 44'h8_0001) begin
      errors++;
      $display("FAIL single_resp: valid=%b paddr=%h hit=%b ppn=%h, want 10 80001000 1 80001", ch_valid_o, ch_paddr_o, ch_dtlb_hit_o, ch_dtlb_ppn_o);
    end
    tick();
    // mmu_valid_i still high but the arbiter is idle now.
    @(negedge clk_i);
    vectors++;
    if (ch_valid_o !== 2'b00 || mmu_req_o !== 1'b0 || ch_paddr_o !== '0) begin
      errors++;
      $display("FAIL idle_valid_ignored: valid=%b req=%b paddr=%h, want 0", ch_valid_o, mmu_req_o, ch_paddr_o);
    end
    tick();
    clear_inputs();
    en_i = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt;
    ch_req_i = 2'b11;
    for (int c = 0; c < 20; c++) begin
      mmu_valid_i = (c % 5 == 4);
      @(negedge clk_i);
      exp_gnt = 2'b00;
      if (c % 5 == 0) exp_gnt = ((c / 5) % 2 == 1) ? 2'b10 : 2'b01;
      vectors++;
      if (ch_gnt_o !== exp_gnt) begin
        errors++;
        $display("FAIL rr_gnt c=%0d: got %b want %b", c, ch_gnt_o, exp_gnt);
      end
      if (c % 5 == 4) begin
        vectors++;
        if (ch_valid_o !== (((c / 5) % 2 == 1) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL rr_valid c=%0d: got %b", c, ch_valid_o);
        end
      end
      if (c % 5 != 0) begin
        vectors++;
        if (mmu_req_o !== 1'b1) begin
          errors++;
          $display("FAIL rr_req c=%0d: got %b want 1", c, mmu_req_o);
        end
      end
      tick();
    end
    ch_req_i    = 2'b00;
    mmu_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    ch_req_i = 2'b11;
    en_i     = 1'b1;
    @(negedge clk_i);
    vectors++;
    if (ch_gnt_o !== 2'b01) begin
      errors++;
      $display("FAIL abort_first_gnt: got %b want 01", ch_gnt_o);
    end
    tick();
    tick();
    tick();
    en_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if (ch_abort_o !== 2'b01 || mmu_req_o !== 1'b0 || ch_valid_o !== 2'b00) begin
      errors++;
      $display("FAIL abort_pulse: abort=%b req=%b valid=%b, want 01 0 00", ch_abort_o, mmu_req_o, ch_valid_o);
    end
    tick();
    en_i = 1'b1;
    @(negedge clk_i);
    vectors++;
    if (ch_gnt_o !== 2'b10 || ch_abort_o !== 2'b00) begin
      errors++;
      $display("FAIL abort_next_gnt: gnt=%b abort=%b, want 10 00", ch_gnt_o, ch_abort_o);
    end
    tick();
    mmu_valid_i = 1'b1;
    @(negedge clk_i);
    vectors++;
    if (ch_valid_o !== 2'b10) begin
      errors++;
      $display("FAIL abort_next_done: got %b want 10", ch_valid_o);
    end
    tick();
    mmu_valid_i = 1'b0;
    ch_req_i    = 2'b00;
    tick();
  endtask

  task automatic test_en_valid_same_cycle();
    ch_req_i = 2'b01;
    en_i     = 1'b1;
    @(negedge clk_i);
    vectors++;
    if (ch_gnt_o !== 2'b01) begin
      errors++;
      $display("FAIL envalid_gnt: got %b want 01", ch_gnt_o);
    end
    tick();
    ch_req_i    = 2'b00;
    en_i        = 1'b0;
    mmu_valid_i = 1'b1;
    @(negedge clk_i);
    vectors++;
    if (ch_valid_o !== 2'b01 || ch_abort_o !== 2'b00) begin
      errors++;
      $display("FAIL envalid_wins: valid=%b abort=%b, want 01 00", ch_valid_o, ch_abort_o);
    end
    tick();
    en_i        = 1'b1;
    mmu_valid_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if (ch_valid_o !== 2'b00 || ch_abort_o !== 2'b00 || mmu_req_o !== 1'b0) begin
      errors++;
      $display("FAIL envalid_after: valid=%b abort=%b req=%b, want 0", ch_valid_o, ch_abort_o, mmu_req_o);
    end
    tick();
  endtask

  task automatic test_disabled();
    en_i     = 1'b0;
    ch_req_i = 2'b11;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      vectors++;
      if (ch_gnt_o !== 2'b00 || mmu_req_o !== 1'b0) begin
        errors++;
        $display("FAIL disabled_no_gnt %0d: gnt=%b req=%b, want 00 0", i, ch_gnt_o, mmu_req_o);
      end
      tick();
    end
    en_i = 1'b1;
    @(negedge clk_i);
    vectors++;
    if (ch_gnt_o !== 2'b10) begin
      errors++;
      $display("FAIL disabled_then_gnt: got %b want 10", ch_gnt_o);
    end
    tick();
    ch_req_i    = 2'b00;
    mmu_valid_i = 1'b1;
    @(negedge clk_i);
    vectors++;
    if (ch_valid_o !== 2'b10) begin
      errors++;
      $display("FAIL disabled_done: got %b want 10", ch_valid_o);
    end
    tick();
    mmu_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_stats();
    logic [31:0] exp_g, exp_s;
    int          busy_len;
`ifdef ACC_MMU_ARB_STATS_EN
    exp_g = 32'd4;
    exp_s = 32'd6;
`else
    exp_g = 32'd0;
    exp_s = 32'd0;
`endif
    apply_reset();
    en_i     = 1'b1;
    ch_req_i = 2'b01;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      vectors++;
      if (ch_gnt_o !== 2'b01) begin
        errors++;
        $display("FAIL stats_gnt k=%0d: got %b want 01", k, ch_gnt_o);
      end
      tick();
      busy_len = (k == 3) ? 3 : 1;
      for (int b = 0; b < busy_len; b++) begin
        mmu_valid_i = (b == busy_len - 1);
        tick();
      end
      mmu_valid_i = 1'b0;
    end
    ch_req_i = 2'b00;
    @(negedge clk_i);
    vectors++;
    if (stat_grants_o !== exp_g || stat_stall_o !== exp_s) begin
      errors++;
      $display("FAIL stats_counts: grants=%0d stall=%0d, want %0d %0d", stat_grants_o, stat_stall_o, exp_g, exp_s);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_abort();
    test_en_valid_same_cycle();
    test_disabled();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/acc_mmu_arbiter.md
ACC_MMU_ARBITER -- requirements
Module: acc_mmu_arbiter

Interface
REQ-001 SHALL have parameter NrChannels, default 2, number of accelerator MMU requesters (1..8).
REQ-002 SHALL have parameter VLEN, default 64, virtual address width.
REQ-003 SHALL have parameter PLEN, default 56, physical address width.
REQ-004 SHALL have parameter PPNW, default 44, DTLB PPN width.
REQ-005 SHALL have parameter ExcW, default 203, opaque exception bundle width.
REQ-006 SHALL have ports: clk_i in 1, the single clock; rst_ni in 1, asynchronous active-low reset.
REQ-007 SHALL have ports: en_i in 1 (accelerator MMU enable); ch_req_i in NrChannels; ch_vaddr_i in NrChannels*VLEN; ch_is_store_i in NrChannels; ch_misaligned_ex_i in NrChannels.
REQ-008 SHALL have ports: ch_gnt_o out NrChannels; ch_valid_o out NrChannels; ch_abort_o out NrChannels; ch_paddr_o out PLEN; ch_exception_o out ExcW; ch_dtlb_hit_o out 1; ch_dtlb_ppn_o out PPNW (response fields broadcast, qualified per channel by ch_valid_o).
REQ-009 SHALL have ports: mmu_req_o out 1; mmu_vaddr_o out VLEN; mmu_is_store_o out 1; mmu_misaligned_ex_o out 1; mmu_valid_i in 1; mmu_paddr_i in PLEN; mmu_exception_i in ExcW; mmu_dtlb_hit_i in 1; mmu_dtlb_ppn_i in PPNW.
REQ-010 SHALL have ports: stat_grants_o out 32; stat_stall_o out 32.

Function
REQ-011 FSM states IDLE, BUSY; one translation outstanding at a time.
REQ-012 IDLE, en_i=1, any ch_req_i: winner = first requester at or after rr_ptr (wrapping modulo NrChannels); ch_gnt_o[winner]=1 combinationally that cycle; vaddr/is_store/misaligned latched; owner=winner; next state BUSY.
REQ-013 IDLE with en_i=0: no grant, ch_gnt_o=0, state stays IDLE.
REQ-014 BUSY: mmu_req_o=1 with latched fields stable until completion; channel inputs ignored.
REQ-015 BUSY and mmu_valid_i=1: ch_valid_o[owner]=1 same cycle, response fields passed through combinationally; rr_ptr=(owner+1) mod NrChannels; next state IDLE.
REQ-016 Minimum grant-to-grant spacing 2 cycles after completion (IDLE bubble); request-in to mmu_req_o latency 1 cycle.
REQ-017 BUSY and en_i=0 (and mmu_valid_i=0): mmu_req_o=0 that cycle, ch_abort_o[owner]=1 one cycle, next state IDLE, rr_ptr advanced as in REQ-015.
REQ-018 BUSY, en_i=0 and mmu_valid_i=1 same cycle: completion wins; ch_valid_o asserted, no abort.
REQ-019 mmu_valid_i in IDLE SHALL be ignored; ch_valid_o stays 0.
REQ-020 ch_gnt_o, ch_valid_o, ch_abort_o each at most one-hot and only one of the three asserted per cycle.
REQ-021 NrChannels=1: rr_ptr constant 0, behaviour otherwise identical.

Reset
REQ-022 rst_ni low: state IDLE, rr_ptr=0, owner=0, latched fields 0, counters 0; all outputs 0 while in reset and first cycle after.
REQ-023 Reset mid-BUSY SHALL drop the transaction with no ch_valid_o or ch_abort_o.

Configuration
REQ-024 Macro ACC_MMU_ARB_STATS_EN defined: stat_grants_o counts grants, stat_stall_o counts cycles with ch_req_i nonzero and no ch_gnt_o; both 32-bit saturating at 0xFFFFFFFF.
REQ-025 Macro undefined: no counter flops; stat_grants_o and stat_stall_o tied to 0.

Verification
REQ-026 NrChannels=2, ch_req_i=2'b11 held, MMU answers 3 cycles after each mmu_req_o -> grants alternate ch0,ch1,ch0,ch1; each grant 5 cycles apart.
REQ-027 Single ch1 request vaddr=0x8000_1000, mmu_paddr_i=0x8000_1000, dtlb_hit=1 -> mmu_vaddr_o=0x8000_1000 one cycle after grant; ch_valid_o=2'b10 with paddr matching.
REQ-028 en_i dropped 2 cycles into BUSY -> ch_abort_o[owner] one pulse, mmu_req_o=0 same cycle, next grant to other channel.
REQ-029 en_i drop coincident with mmu_valid_i -> ch_valid_o pulse, no ch_abort_o.
REQ-030 rst_ni asserted mid-BUSY -> all outputs 0, no response pulse; after release ch0 wins first.
REQ-031 With ACC_MMU_ARB_STATS_EN, 4 grants and 6 stall cycles -> stat_grants_o=4, stat_stall_o=6; without macro both 0.
